wptr_full_ctrl: RTL and testbench
=================================

WPTR_FULL_CTRL -- requirements
Module: wptr_full_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 3, the FIFO address width; DEPTH = 2**ADDR_WIDTH.
REQ-002 SHALL have parameter AF_MARGIN, default 1, the almost-full margin in entries (1..DEPTH-1).
REQ-003 SHALL have port clk_in, input, 1, the single write-domain clock; all logic is on its rising edge.
REQ-004 SHALL have port reset_in, input, 1, synchronous active-high reset.
REQ-005 SHALL have port wr_en_in, input, 1, write request from the producer.
REQ-006 SHALL have port rd_ptr_sync_in, input, ADDR_WIDTH+1, read pointer already converted to binary and synchronized into this domain by the pointer-crossing stage.
REQ-007 SHALL have port overflow_clr_in, input, 1, clears the sticky overflow flag.
REQ-008 SHALL have port wr_ptr_out, output, ADDR_WIDTH+1, registered binary write pointer with wrap bit; it feeds the binary-to-grey pointer-crossing stage toward the read domain.
REQ-009 SHALL have port wr_addr_out, output, ADDR_WIDTH, RAM write address = wr_ptr_out[ADDR_WIDTH-1:0].
REQ-010 SHALL have port mem_wr_en_out, output, 1, RAM write strobe.
REQ-011 SHALL have port full_out, output, 1, registered full flag.
REQ-012 SHALL have port almost_full_out, output, 1, registered almost-full flag.
REQ-013 SHALL have port wr_level_out, output, ADDR_WIDTH+1, registered fill level as seen from the write domain.
REQ-014 SHALL have port overflow_out, output, 1, sticky flag: a write was attempted while full.

Function
REQ-015 SHALL define accept = wr_en_in AND NOT full_out; mem_wr_en_out SHALL equal accept combinationally, and wr_addr_out SHALL be combinational from the current pointer.
REQ-016 SHALL set wr_ptr_next = wr_ptr_out + accept, modulo 2**(ADDR_WIDTH+1), and register it each cycle; all-ones SHALL wrap to 0 with the wrap bit toggling at each DEPTH boundary.
REQ-017 SHALL compute level_next = (wr_ptr_next - rd_ptr_sync_in) modulo 2**(ADDR_WIDTH+1), using the current-cycle rd_ptr_sync_in.
REQ-018 SHALL register wr_level_out = min(level_next, DEPTH); a raw level above DEPTH SHALL saturate to DEPTH.
REQ-019 SHALL register full_out = (level_next >= DEPTH), i.e. next pointer equals the read pointer with the MSB inverted and lower bits equal.
REQ-020 SHALL register almost_full_out = (level_next >= DEPTH - AF_MARGIN).
REQ-021 SHALL make full and almost-full assertion visible in the cycle right after the accepting edge, so a write is never accepted into a full FIFO.
REQ-022 SHALL deassert full_out one cycle after rd_ptr_sync_in advances so that level_next < DEPTH, with no dependence on wr_en_in.
REQ-023 SHALL take both a write acceptance and a rd_ptr_sync_in change in the same cycle into level_next; the net level is unchanged.
REQ-024 SHALL, when wr_en_in AND full_out, accept no write, leave the pointer unchanged, and set overflow_out on the next edge.
REQ-025 SHALL clear overflow_out on the next edge when overflow_clr_in is high; a simultaneous set SHALL win.

Reset
REQ-026 SHALL, on reset_in high at a rising edge, set wr_ptr_out=0, wr_level_out=0, full_out=0, almost_full_out=0 and overflow_out=0, regardless of the other inputs.
REQ-027 SHALL force mem_wr_en_out=0 while reset_in is high.
REQ-028 SHALL, on reset mid-operation (for example while full), return all outputs to their REQ-026 values one edge later; the producer and consumer domains SHALL be reset together.

Verification (ADDR_WIDTH=3, DEPTH=8, AF_MARGIN=1)
REQ-029 SHALL cover reset: hold reset_in for 3 cycles with wr_en_in=1 -> all outputs are 0 and mem_wr_en_out=0 throughout.
REQ-030 SHALL cover filling: rd_ptr_sync_in=0 with 8 consecutive writes -> wr_ptr_out counts 1..8, almost_full_out=1 after the 7th accept, full_out=1 after the 8th, and wr_level_out=8.
REQ-031 SHALL cover overflow: write while full -> mem_wr_en_out=0, wr_ptr_out stays 8, overflow_out=1 next cycle; pulse overflow_clr_in -> overflow_out=0.
REQ-032 SHALL cover drain: step rd_ptr_sync_in 0->1 while full -> full_out=0 and wr_level_out=7 one cycle later; the next write refills to full.
REQ-033 SHALL cover wrap-around: run 20 writes with rd_ptr_sync_in tracking 2 behind -> wr_ptr_out wraps 15->0, wr_level_out stays 2, full_out stays 0.
REQ-034 SHALL cover a simultaneous write and read at level 5 -> wr_level_out stays 5 with flags unchanged; an end-to-end bench through the pointer-crossing stage shows the read side's wr_ptr_out arriving 2 cycles later.

Source files
------------

// File: rtl/wptr_full_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wptr_full_ctrl : async-FIFO write pointer, full/almost-full, level, ovf  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module wptr_full_ctrl #(
  parameter int ADDR_WIDTH = 3,
  parameter int AF_MARGIN  = 1
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic                  wr_en_in,
  input  logic [ADDR_WIDTH:0]   rd_ptr_sync_in,
  input  logic                  overflow_clr_in,
  output logic [ADDR_WIDTH:0]   wr_ptr_out,
  output logic [ADDR_WIDTH-1:0] wr_addr_out,
  output logic                  mem_wr_en_out,
  output logic                  full_out,
  output logic                  almost_full_out,
  output logic [ADDR_WIDTH:0]   wr_level_out,
  output logic                  overflow_out
);

  localparam logic [ADDR_WIDTH:0] c_DEPTH     = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] c_AF_MARGIN = AF_MARGIN[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] c_AF_THRESH = c_DEPTH - c_AF_MARGIN;

  logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0] level_q, level_d;
  logic                full_q, full_d;
  logic                afull_q, afull_d;
  logic                ovf_q, ovf_d;
  logic                w_accept;
  logic [ADDR_WIDTH:0] w_level_next;

  always_comb begin
    // Gating with reset keeps the RAM quiet while both domains are held.
    w_accept     = wr_en_in & ~full_q & ~reset_in;
    wr_ptr_d     = wr_ptr_q + {{ADDR_WIDTH{1'b0}}, w_accept};
    w_level_next = wr_ptr_d - rd_ptr_sync_in;
    full_d       = (w_level_next >= c_DEPTH);
    level_d      = full_d ? c_DEPTH : w_level_next;
    afull_d      = (w_level_next >= c_AF_THRESH);
    if (wr_en_in && full_q) begin
      ovf_d = 1'b1;
    end else if (overflow_clr_in) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      wr_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
      ovf_q    <= ovf_d;
    end
  end

  assign wr_ptr_out      = wr_ptr_q;
  assign wr_addr_out     = wr_ptr_q[ADDR_WIDTH-1:0];
  assign mem_wr_en_out   = w_accept;
  assign full_out        = full_q;
  assign almost_full_out = afull_q;
  assign wr_level_out    = level_q;
  assign overflow_out    = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_wptr_full_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_wptr_full_ctrl : directed vectors with queued expectations            |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_wptr_full_ctrl;

  logic       clk_in = 1'b0;
  logic       reset_in = 1'b1;
  logic       wr_en_in = 1'b0;
  logic [3:0] rd_ptr_sync_in = '0;
  logic       overflow_clr_in = 1'b0;
  logic [3:0] wr_ptr_out;
  logic [2:0] wr_addr_out;
  logic       mem_wr_en_out;
  logic       full_out;
  logic       almost_full_out;
  logic [3:0] wr_level_out;
  logic       overflow_out;

  wptr_full_ctrl #(.ADDR_WIDTH(3), .AF_MARGIN(1)) dut (
    .clk_in          (clk_in),
    .reset_in        (reset_in),
    .wr_en_in        (wr_en_in),
    .rd_ptr_sync_in  (rd_ptr_sync_in),
    .overflow_clr_in (overflow_clr_in),
    .wr_ptr_out      (wr_ptr_out),
    .wr_addr_out     (wr_addr_out),
    .mem_wr_en_out   (mem_wr_en_out),
    .full_out        (full_out),
    .almost_full_out (almost_full_out),
    .wr_level_out    (wr_level_out),
    .overflow_out    (overflow_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic       mem;
    logic [3:0] ptr;
    logic [3:0] lvl;
    logic       full;
    logic       af;
    logic       ovf;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   busy     = 1'b0;

  function automatic void chk(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Inputs change just after the falling edge; expectations describe the
  // pre-edge strobe and the registered state after the next rising edge.
  task automatic step(input logic rst, input logic wr, input logic [3:0] rd,
                      input logic clr, input logic mem, input logic [3:0] ptr,
                      input logic [3:0] lvl, input logic full, input logic af,
                      input logic ovf);
    exp_t e;
    @(negedge clk_in);
    #1;
    reset_in        = rst;
    wr_en_in        = wr;
    rd_ptr_sync_in  = rd;
    overflow_clr_in = clr;
    e.mem = mem; e.ptr = ptr; e.lvl = lvl; e.full = full; e.af = af; e.ovf = ovf;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t       e;
    logic [3:0] prev_ptr = '0;
    bit         prev_ok  = 1'b0;
    forever begin
      @(negedge clk_in);
      #3;
      if (q.size() > 0) begin
        busy = 1'b1;
        e = q.pop_front();
        chk("mem_wr_en", {7'd0, mem_wr_en_out}, {7'd0, e.mem});
        if (prev_ok) chk("wr_addr", {5'd0, wr_addr_out}, {5'd0, prev_ptr[2:0]});
        @(posedge clk_in);
        #1;
        chk("wr_ptr", {4'd0, wr_ptr_out}, {4'd0, e.ptr});
        chk("wr_level", {4'd0, wr_level_out}, {4'd0, e.lvl});
        chk("full", {7'd0, full_out}, {7'd0, e.full});
        chk("almost_full", {7'd0, almost_full_out}, {7'd0, e.af});
        chk("overflow", {7'd0, overflow_out}, {7'd0, e.ovf});
        prev_ptr = e.ptr;
        prev_ok  = 1'b1;
        busy     = 1'b0;
      end
    end
  end

  initial begin : driver
    logic [3:0] p;
    // Reset held three cycles with a pending write.
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    // Fill from empty.
    for (int i = 1; i <= 8; i++)
      step(0, 1, 0, 0, 1, 4'(i), 4'(i), (i == 8), (i >= 7), 0);
    // Overflow, sticky hold, clear, set-wins-over-clear, clear.
    step(0, 1, 0, 0, 0, 8, 8, 1, 1, 1);
    step(0, 0, 0, 0, 0, 8, 8, 1, 1, 1);
    step(0, 0, 0, 1, 0, 8, 8, 1, 1, 0);
    step(0, 1, 0, 1, 0, 8, 8, 1, 1, 1);
    step(0, 0, 0, 1, 0, 8, 8, 1, 1, 0);
    // Drain one entry, then refill.
    step(0, 0, 1, 0, 0, 8, 7, 0, 1, 0);
    step(0, 1, 1, 0, 1, 9, 8, 1, 1, 0);
    // Read side catches up to two behind, then 20 writes across the wrap.
    step(0, 0, 7, 0, 0, 9, 2, 0, 0, 0);
    p = 4'd9;
    for (int i = 0; i < 20; i++) begin
      p = p + 4'd1;
      step(0, 1, p - 4'd2, 0, 1, p, 2, 0, 0, 0);
    end
    // p is now 13: set level 5, then simultaneous write and read.
    step(0, 0, 8, 0, 0, 13, 5, 0, 0, 0);
    step(0, 1, 9, 0, 1, 14, 5, 0, 0, 0);
    // Almost-full threshold across the pointer wrap.
    step(0, 1, 9, 0, 1, 15, 6, 0, 0, 0);
    step(0, 1, 9, 0, 1, 0, 7, 0, 1, 0);
    // Raw level 12 saturates to 8, then overflow while full.
    step(0, 0, 4, 0, 0, 0, 8, 1, 1, 0);
    step(0, 1, 4, 0, 0, 0, 8, 1, 1, 1);
    // Refill to full at a non-zero pointer, then reset mid-operation.
    step(0, 0, 12, 0, 0, 0, 4, 0, 0, 1);
    step(0, 1, 12, 0, 1, 1, 5, 0, 0, 1);
    step(0, 0, 9, 0, 0, 1, 8, 1, 1, 1);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1, 1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1, 0, 0, 0);

    for (int i = 0; i < 20 && (q.size() > 0 || busy); i++) @(posedge clk_in);
    #3;
    if (q.size() > 0 || busy) begin
      failures++;
      $display("FAIL drain_timeout got=%0d want=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
